// File: rtl/conv_img_loader.sv
`default_nettype none
// ============================================================================
//  Module      : conv_img_loader
//  Description : Streams raster-order pixels into FILTER_W column banks per
//                channel, then hands the loaded frame to a convolution engine
//                via a val/rdy handshake and waits for it to finish.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_img_loader #(
  parameter  int DATA_WIDTH = 8,
  parameter  int IMG_W      = 8,
  parameter  int IMG_H      = 8,
  parameter  int IMG_D      = 4,
  parameter  int FILTER_W   = 3,
  localparam int BANK_COLS  = (IMG_W + FILTER_W - 1) / FILTER_W,
  localparam int BANK_DEPTH = BANK_COLS * IMG_H,
  localparam int ADDR_WIDTH = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH*IMG_D-1:0] pix_data,
  input  logic                        pix_val,
  output logic                        pix_rdy,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [DATA_WIDTH*IMG_D-1:0] wr_data,
  output logic [FILTER_W-1:0]         wr_en,
  output logic                        conv_val,
  input  logic                        conv_rdy,
  output logic                        frame_done
);

  localparam int W_CNT_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int H_CNT_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int BANK_SEL_W = (FILTER_W > 1) ? $clog2(FILTER_W) : 1;

  localparam logic [W_CNT_W-1:0]    C_W_LAST    = W_CNT_W'(IMG_W - 1);
  localparam logic [H_CNT_W-1:0]    C_H_LAST    = H_CNT_W'(IMG_H - 1);
  localparam logic [BANK_SEL_W-1:0] C_BANK_LAST = BANK_SEL_W'(FILTER_W - 1);
  localparam logic [ADDR_WIDTH-1:0] C_ROW_STEP  = ADDR_WIDTH'(BANK_COLS);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT1 = 2'd2,
    BUSY  = 2'd3
  } state_t;

  state_t                r_state;
  logic [W_CNT_W-1:0]    r_w;
  logic [H_CNT_W-1:0]    r_h;
  // Bank select, column word and row base are tracked incrementally so the
  // address never needs a divider: addr = row_base + col.
  logic [BANK_SEL_W-1:0] r_bank;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [ADDR_WIDTH-1:0] r_row_base;

  logic w_accept;
  logic w_last_px;

  assign pix_rdy   = (r_state == LOAD);
  assign w_accept  = pix_val && pix_rdy;
  assign w_last_px = (r_w == C_W_LAST) && (r_h == C_H_LAST);

  // Frame-level control: load, offer frame to conv engine, wait for it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= LOAD;
      conv_val   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_accept && w_last_px) begin
            r_state <= START;
          end
        end
        START: begin
          // conv_val rises one cycle after the final bank write is presented.
          if (!conv_val) begin
            conv_val <= 1'b1;
          end else if (conv_rdy) begin
            conv_val <= 1'b0;
            r_state  <= WAIT1;
          end
        end
        WAIT1: begin
          // The engine still shows rdy on this cycle; skip it.
          r_state <= BUSY;
        end
        BUSY: begin
          if (conv_rdy) begin
            r_state    <= LOAD;
            frame_done <= 1'b1;
          end
        end
        default: begin
          r_state  <= LOAD;
          conv_val <= 1'b0;
        end
      endcase
    end
  end

  // Raster position counters, advanced once per accepted pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w        <= '0;
      r_h        <= '0;
      r_bank     <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (w_accept) begin
      if (r_w == C_W_LAST) begin
        r_w    <= '0;
        r_bank <= '0;
        r_col  <= '0;
        if (r_h == C_H_LAST) begin
          r_h        <= '0;
          r_row_base <= '0;
        end else begin
          r_h        <= r_h + H_CNT_W'(1);
          r_row_base <= r_row_base + C_ROW_STEP;
        end
      end else begin
        r_w <= r_w + W_CNT_W'(1);
        if (r_bank == C_BANK_LAST) begin
          r_bank <= '0;
          r_col  <= r_col + ADDR_WIDTH'(1);
        end else begin
          r_bank <= r_bank + BANK_SEL_W'(1);
        end
      end
    end
  end

  // Registered bank write port; address/data hold when no write is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (w_accept) begin
      wr_en   <= FILTER_W'(1) << r_bank;
      wr_addr <= r_row_base + r_col;
      wr_data <= pix_data;
    end else begin
      wr_en <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_img_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_img_loader
//  Description : Self-checking bench for conv_img_loader (8x8x4, 3 banks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_img_loader;

  localparam int DW   = 8;
  localparam int IW   = 8;
  localparam int IH   = 8;
  localparam int ID   = 4;
  localparam int FW   = 3;
  localparam int PW   = DW * ID;
  localparam int BC   = (IW + FW - 1) / FW;
  localparam int AW   = 5;
  localparam int NPIX = IW * IH;

  logic          clk;
  logic          reset;
  logic [PW-1:0] pix_data;
  logic          pix_val;
  logic          pix_rdy;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic [FW-1:0] wr_en;
  logic          conv_val;
  logic          conv_rdy;
  logic          frame_done;

  conv_img_loader #(
    .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .IMG_D(ID), .FILTER_W(FW)
  ) dut (
    .clk(clk), .reset(reset), .pix_data(pix_data), .pix_val(pix_val),
    .pix_rdy(pix_rdy), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .conv_val(conv_val), .conv_rdy(conv_rdy), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: pixels accepted so far in the current frame and
  // the write port values the loader should currently present.
  int            n        = 0;
  logic          loading  = 1'b1;
  logic          exp_cv   = 1'b0;
  logic          exp_fd   = 1'b0;
  logic [FW-1:0] e_en     = '0;
  logic [AW-1:0] e_addr   = '0;
  logic [PW-1:0] e_data   = '0;
  int            last_idx = -1;
  int            obs_writes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, step past the edge, compare against the model.
  task automatic cycle(input logic val, input logic [PW-1:0] data, input logic crdy);
    logic acc;
    int   w, h;
    pix_val  = val;
    pix_data = data;
    conv_rdy = crdy;
    check("pix_rdy", {63'd0, pix_rdy}, {63'd0, loading});
    acc = val && loading;
    last_idx = -1;
    @(posedge clk);
    #1;
    if (acc) begin
      w      = n % IW;
      h      = n / IW;
      e_en   = FW'(1 << (w % FW));
      e_addr = AW'(w / FW + h * BC);
      e_data = data;
      last_idx = n;
      n++;
      if (n == NPIX) begin
        n       = 0;
        loading = 1'b0;
      end
    end else begin
      e_en = '0;
    end
    if (wr_en !== '0) obs_writes++;
    check("wr_en",      {61'd0, wr_en},      {61'd0, e_en});
    check("wr_addr",    {59'd0, wr_addr},    {59'd0, e_addr});
    check("wr_data",    {32'd0, wr_data},    {32'd0, e_data});
    check("conv_val",   {63'd0, conv_val},   {63'd0, exp_cv});
    check("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
  endtask

  // mode 0: val always 1, data = pixel index; mode 1: val toggles; mode 2: random.
  task automatic load_frame(input int mode, input int stop_at);
    int            acc_cnt = 0;
    int            budget  = 0;
    logic          v       = 1'b0;
    logic [PW-1:0] d;
    obs_writes = 0;
    while (loading && acc_cnt < stop_at && budget < 2000) begin
      case (mode)
        0:       begin v = 1'b1;           d = PW'(n);        end
        1:       begin v = ~v;             d = PW'($urandom); end
        default: begin v = $urandom % 2 == 1; d = PW'($urandom); end
      endcase
      cycle(v, d, 1'b0);
      if (last_idx >= 0) acc_cnt++;
      if (last_idx == 0) begin
        check("px00_en",   {61'd0, wr_en},   64'd1);
        check("px00_addr", {59'd0, wr_addr}, 64'd0);
      end
      if (last_idx == 20) begin
        check("px42_en",   {61'd0, wr_en},   64'd2);
        check("px42_addr", {59'd0, wr_addr}, 64'd7);
      end
      if (last_idx == 63) begin
        check("px77_en",   {61'd0, wr_en},   64'd2);
        check("px77_addr", {59'd0, wr_addr}, 64'd23);
      end
      budget++;
    end
    if (budget >= 2000) begin
      compared++;
      mismatched++;
      $error("FAIL load_timeout: observed %0d accepted expected %0d", acc_cnt, stop_at);
    end
  endtask

  // Handshake with the conv engine: conv_rdy low for 'hold' cycles while the
  // frame is offered, accept, one ignored cycle, 'busy' cycles, then done.
  task automatic conv_run(input int hold, input int busy);
    exp_cv = 1'b1;
    repeat (hold) cycle($urandom % 2 == 1, PW'($urandom), 1'b0);
    exp_cv = 1'b0;
    cycle($urandom % 2 == 1, PW'($urandom), 1'b1);
    cycle($urandom % 2 == 1, PW'($urandom), 1'b1);
    repeat (busy) cycle($urandom % 2 == 1, PW'($urandom), 1'b0);
    exp_fd = 1'b1;
    cycle($urandom % 2 == 1, PW'($urandom), 1'b1);
    exp_fd  = 1'b0;
    loading = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_rdy"},  {63'd0, pix_rdy},    64'd1);
    check({tag, "_wr_en"},    {61'd0, wr_en},      64'd0);
    check({tag, "_wr_addr"},  {59'd0, wr_addr},    64'd0);
    check({tag, "_wr_data"},  {32'd0, wr_data},    64'd0);
    check({tag, "_conv_val"}, {63'd0, conv_val},   64'd0);
    check({tag, "_frm_done"}, {63'd0, frame_done}, 64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    pix_val  = 1'b0;
    pix_data = '0;
    conv_rdy = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Frame 1: continuous stream, index data, long conv handshake.
    load_frame(0, NPIX);
    check("f1_writes", 64'(obs_writes), 64'(NPIX));
    conv_run(10, 20);

    // Frame 2: pix_val toggles every cycle.
    load_frame(1, NPIX);
    check("f2_writes", 64'(obs_writes), 64'(NPIX));
    conv_run(1, 3);

    // Frame 3: random valid, aborted by reset after 30 pixels.
    load_frame(2, 30);
    pix_val = 1'b1;
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    n       = 0;
    loading = 1'b1;
    e_en    = '0;
    e_addr  = '0;
    e_data  = '0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    reset = 1'b1;

    // Frame 4: full random-valid frame after the abort.
    load_frame(2, NPIX);
    check("f4_writes", 64'(obs_writes), 64'(NPIX));
    conv_run(2, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
